dma_arbiter: RTL and testbench

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter.sv | 145 ++++++++++++++
 tb/tb_dma_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// Four-channel DMA request arbiter: fixed or rotating priority, HRQ/HLDA bus hold
// handshake with the CPU, and one-hot DACK while the winning channel is in service.
module dma_arbiter #(
   parameter bit DREQ_ACTIVE_HIGH = 1'b1,
   parameter bit DACK_ACTIVE_HIGH = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       DREQ0,
   input  logic       DREQ1,
   input  logic       DREQ2,
   input  logic       DREQ3,
   input  logic       HLDA,
   input  logic [3:0] MASK,
   input  logic       CMD_DISABLE,
   input  logic       CMD_ROTATE,
   input  logic       XFER_DONE,
   output logic       HRQ,
   output logic       DACK0,
   output logic       DACK1,
   output logic       DACK2,
   output logic       DACK3,
   output logic       ACT_VALID,
   output logic [1:0] ACT_CH,
   output logic       GRANT_START,
   output logic       ABORT,
   output logic [1:0] state_dbg,
   output logic [1:0] ptr_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      GRANT   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t     state_q, state_n;
   logic [1:0] ptr_q, ptr_n;
   logic [1:0] act_ch_q, act_ch_n;
   logic       hrq_q, hrq_n;
   logic       act_valid_q, act_valid_n;
   logic       grant_start_q, grant_start_n;
   logic       abort_q, abort_n;
   logic [3:0] dack_q, dack_n;

   logic [3:0] dreq_act;
   logic [3:0] eff_req;
   logic [1:0] base;
   logic [1:0] cand;
   logic       win_valid;
   logic [1:0] win_ch;

   // Priority search starts at the rotation pointer (or channel 0 in fixed mode).
   always_comb begin
      dreq_act  = DREQ_ACTIVE_HIGH ? {DREQ3, DREQ2, DREQ1, DREQ0}
                                   : ~{DREQ3, DREQ2, DREQ1, DREQ0};
      eff_req   = dreq_act & ~MASK & {4{~CMD_DISABLE}};
      base      = CMD_ROTATE ? ptr_q : 2'd0;
      cand      = 2'd0;
      win_valid = 1'b0;
      win_ch    = 2'd0;
      for (int i = 0; i < 4; i++) begin
         cand = base + 2'(i);
         if (!win_valid && eff_req[cand]) begin
            win_valid = 1'b1;
            win_ch    = cand;
         end
      end
   end

   // Handshake: HRQ rises one cycle after a request wins in IDLE and stays high
   // until HLDA is sampled high; service runs while HLDA stays high and ends on
   // XFER_DONE (normal) or HLDA low (abort). RELEASE waits for HLDA to drop.
   always_comb begin
      state_n  = state_q;
      ptr_n    = ptr_q;
      act_ch_n = act_ch_q;
      abort_n  = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_n  = REQ;
               act_ch_n = win_ch;
            end
         end
         REQ: begin
            if (HLDA) state_n = GRANT;
         end
         GRANT: begin
            if (XFER_DONE) begin
               state_n = RELEASE;
               ptr_n   = act_ch_q + 2'd1;
            end else if (!HLDA) begin
               state_n = RELEASE;
               ptr_n   = act_ch_q + 2'd1;
               abort_n = 1'b1;
            end
         end
         RELEASE: begin
            if (!HLDA) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      hrq_n         = (state_n == REQ) || (state_n == GRANT);
      act_valid_n   = (state_n == GRANT);
      grant_start_n = (state_q == REQ) && (state_n == GRANT);
      dack_n        = act_valid_n ? (4'b0001 << act_ch_n) : 4'b0000;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= IDLE;
         ptr_q         <= 2'd0;
         act_ch_q      <= 2'd0;
         hrq_q         <= 1'b0;
         act_valid_q   <= 1'b0;
         grant_start_q <= 1'b0;
         abort_q       <= 1'b0;
         dack_q        <= DACK_ACTIVE_HIGH ? 4'b0000 : 4'b1111;
      end else begin
         state_q       <= state_n;
         ptr_q         <= ptr_n;
         act_ch_q      <= act_ch_n;
         hrq_q         <= hrq_n;
         act_valid_q   <= act_valid_n;
         grant_start_q <= grant_start_n;
         abort_q       <= abort_n;
         dack_q        <= DACK_ACTIVE_HIGH ? dack_n : ~dack_n;
      end
   end

   assign HRQ         = hrq_q;
   assign DACK0       = dack_q[0];
   assign DACK1       = dack_q[1];
   assign DACK2       = dack_q[2];
   assign DACK3       = dack_q[3];
   assign ACT_VALID   = act_valid_q;
   assign ACT_CH      = act_ch_q;
   assign GRANT_START = grant_start_q;
   assign ABORT       = abort_q;
   assign state_dbg   = state_q;
   assign ptr_dbg     = ptr_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: expected grant channels are queued when a request
// is issued and checked by a monitor on every GRANT_START pulse.
module tb_dma_arbiter;

   localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_GRANT = 2'd2, S_RELEASE = 2'd3;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [3:0] dreq = 4'b0000;
   logic       HLDA = 1'b0;
   logic [3:0] MASK = 4'b0000;
   logic       CMD_DISABLE = 1'b0;
   logic       CMD_ROTATE = 1'b0;
   logic       XFER_DONE = 1'b0;
   logic       HRQ, DACK0, DACK1, DACK2, DACK3, ACT_VALID, GRANT_START, ABORT;
   logic [1:0] ACT_CH, state_dbg, ptr_dbg;
   logic [3:0] dack;

   logic [1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int abort_seen = 0;

   assign dack = {DACK3, DACK2, DACK1, DACK0};

   dma_arbiter dut (
      .CLK(CLK), .RESET(RESET),
      .DREQ0(dreq[0]), .DREQ1(dreq[1]), .DREQ2(dreq[2]), .DREQ3(dreq[3]),
      .HLDA(HLDA), .MASK(MASK), .CMD_DISABLE(CMD_DISABLE), .CMD_ROTATE(CMD_ROTATE),
      .XFER_DONE(XFER_DONE), .HRQ(HRQ),
      .DACK0(DACK0), .DACK1(DACK1), .DACK2(DACK2), .DACK3(DACK3),
      .ACT_VALID(ACT_VALID), .ACT_CH(ACT_CH), .GRANT_START(GRANT_START), .ABORT(ABORT),
      .state_dbg(state_dbg), .ptr_dbg(ptr_dbg)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge CLK) begin
      if (!RESET && ABORT) abort_seen++;
      if (!RESET && GRANT_START) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected: got ch %0d expected none", ACT_CH);
         end else begin
            logic [1:0] e;
            e = exp_q.pop_front();
            if (ACT_CH !== e || dack !== (4'b0001 << e) || ACT_VALID !== 1'b1) begin
               errors++;
               $display("FAIL grant_ch: got ch %0d dack %b expected ch %0d dack %b",
                        ACT_CH, dack, e, 4'b0001 << e);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_hrq();
      for (int n = 0; n < 20 && !HRQ; n++) tick();
      check("hrq_wait", HRQ, 1);
   endtask

   task automatic wait_grant();
      for (int n = 0; n < 20 && !ACT_VALID; n++) tick();
      check("grant_wait", ACT_VALID, 1);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   task automatic serve(input logic [1:0] ch);
      exp_q.push_back(ch);
      wait_hrq();
      HLDA = 1'b1;
      wait_grant();
      tick();
      tick();
      XFER_DONE = 1'b1;
      tick();
      XFER_DONE = 1'b0;
      check("svc_dack_off", dack, 4'b0000);
      check("svc_valid_off", ACT_VALID, 0);
      HLDA = 1'b0;
      tick();
      check("svc_idle", state_dbg, S_IDLE);
   endtask

   initial begin
      do_reset();
      check("rst_state", state_dbg, S_IDLE);
      check("rst_hrq", HRQ, 0);
      check("rst_dack", dack, 4'b0000);
      check("rst_ptr", ptr_dbg, 0);

      // fixed priority, DREQ1 and DREQ3 together
      dreq = 4'b1010;
      exp_q.push_back(2'd1);
      tick();
      check("fix_hrq_lat", HRQ, 1);
      check("fix_act_ch", ACT_CH, 1);
      tick();
      tick();
      HLDA = 1'b1;
      check("fix_no_dack_yet", dack, 4'b0000);
      tick();
      check("fix_dack1", dack, 4'b0010);
      check("fix_gs", GRANT_START, 1);
      tick();
      check("fix_gs_pulse", GRANT_START, 0);
      XFER_DONE = 1'b1;
      tick();
      XFER_DONE = 1'b0;
      check("fix_rel_dack", dack, 4'b0000);
      check("fix_rel_hrq", HRQ, 0);
      tick();
      check("fix_rel_hold", state_dbg, S_RELEASE);
      dreq = 4'b0000;
      HLDA = 1'b0;
      tick();
      check("fix_idle", state_dbg, S_IDLE);
      check("fix_ptr", ptr_dbg, 2);

      // rotating priority wrap
      do_reset();
      CMD_ROTATE = 1'b1;
      dreq = 4'b1111;
      serve(2'd0);
      serve(2'd1);
      serve(2'd2);
      serve(2'd3);
      serve(2'd0);

      // masking and global disable
      CMD_ROTATE = 1'b0;
      dreq = 4'b0101;
      MASK = 4'b0001;
      serve(2'd2);
      MASK = 4'b0000;
      dreq = 4'b1111;
      CMD_DISABLE = 1'b1;
      for (int n = 0; n < 20; n++) begin
         tick();
         check("disable_hrq", HRQ, 0);
      end
      dreq = 4'b0000;
      CMD_DISABLE = 1'b0;

      // completion and HLDA drop in the same cycle is not an abort
      dreq = 4'b0001;
      exp_q.push_back(2'd0);
      wait_hrq();
      HLDA = 1'b1;
      wait_grant();
      dreq = 4'b0000;
      tick();
      XFER_DONE = 1'b1;
      HLDA = 1'b0;
      tick();
      XFER_DONE = 1'b0;
      check("both_no_abort", ABORT, 0);
      check("both_release", state_dbg, S_RELEASE);
      tick();
      check("both_idle", state_dbg, S_IDLE);
      check("both_ptr", ptr_dbg, 1);

      // abort by HLDA drop mid-GRANT
      CMD_ROTATE = 1'b1;
      dreq = 4'b0010;
      exp_q.push_back(2'd1);
      wait_hrq();
      HLDA = 1'b1;
      wait_grant();
      dreq = 4'b0000;
      tick();
      HLDA = 1'b0;
      tick();
      check("abort_pulse", ABORT, 1);
      check("abort_dack", dack, 4'b0000);
      check("abort_hrq", HRQ, 0);
      check("abort_state", state_dbg, S_RELEASE);
      tick();
      check("abort_once", ABORT, 0);
      check("abort_idle", state_dbg, S_IDLE);
      check("abort_ptr", ptr_dbg, 2);

      // reset in the middle of a grant on channel 2
      CMD_ROTATE = 1'b0;
      dreq = 4'b0100;
      exp_q.push_back(2'd2);
      wait_hrq();
      HLDA = 1'b1;
      wait_grant();
      tick();
      RESET = 1'b1;
      tick();
      check("mrst_state", state_dbg, S_IDLE);
      check("mrst_hrq", HRQ, 0);
      check("mrst_dack", dack, 4'b0000);
      check("mrst_valid", ACT_VALID, 0);
      check("mrst_ch", ACT_CH, 0);
      check("mrst_gs", GRANT_START, 0);
      check("mrst_abort", ABORT, 0);
      check("mrst_ptr", ptr_dbg, 0);
      RESET = 1'b0;
      HLDA = 1'b0;
      dreq = 4'b1111;
      CMD_ROTATE = 1'b1;
      serve(2'd0);
      do_reset();
      CMD_ROTATE = 1'b0;
      serve(2'd0);
      dreq = 4'b0000;

      // committed request survives DREQ drop; XFER_DONE outside GRANT ignored
      dreq = 4'b0100;
      exp_q.push_back(2'd2);
      wait_hrq();
      dreq = 4'b0000;
      XFER_DONE = 1'b1;
      tick();
      XFER_DONE = 1'b0;
      check("drop_hrq", HRQ, 1);
      check("drop_state", state_dbg, S_REQ);
      tick();
      check("drop_hrq2", HRQ, 1);
      HLDA = 1'b1;
      wait_grant();
      check("drop_dack2", dack, 4'b0100);
      tick();
      check("drop_dack2_hold", dack, 4'b0100);
      XFER_DONE = 1'b1;
      tick();
      XFER_DONE = 1'b0;
      HLDA = 1'b0;
      tick();
      check("drop_idle", state_dbg, S_IDLE);

      tick();
      check("queue_empty", exp_q.size(), 0);
      check("abort_count", abort_seen, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
